// File: rtl/pong_pkg.sv
// Shared definitions for the Pong match sequencer: state and winner encodings,
// score width and the winner decision helper.
`default_nettype none

package pong_pkg;

  localparam int SCORE_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] s1,
                                           input logic [SCORE_W-1:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_btn_edge.sv
// Optional 2-FF synchronizer followed by a rising-edge detector; pulse is one
// clk wide. With SYNC=0 the input is assumed already synchronous to clk.
`default_nettype none

module pong_btn_edge #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic level;
  logic level_d;

  if (SYNC) begin : g_sync
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], din};
    end
    assign level = sync_q[1];
  end else begin : g_direct
    assign level = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_d <= 1'b0;
    else        level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

`default_nettype wire

// File: rtl/pong_match_sequencer.sv
// Match-level controller for Pong: sequences serve/rally/point/game-over and owns
// both scores. Optional macro PONG_PAUSE_EN adds a PAUSED state toggled by start.
`default_nettype none

module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int PAUSE_TICKS = 200,
  parameter int OVER_TICKS  = 300,
  parameter int CNT_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               miss1,
  input  logic               miss2,
  input  logic               time_up,
  output logic               stop,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [CNT_W-1:0]   OVER_MAX   = CNT_W'(OVER_TICKS);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
  logic [1:0]           win_q, win_d;
  logic                 dir_q, dir_d;
  logic                 br_q, br_d;
  logic                 start_p, miss1_p, miss2_p;

  pong_btn_edge #(.SYNC(1'b1)) u_start_edge (
    .clk(clk), .rst_n(rst_n), .din(start), .pulse(start_p)
  );
  pong_btn_edge #(.SYNC(1'b0)) u_miss1_edge (
    .clk(clk), .rst_n(rst_n), .din(miss1), .pulse(miss1_p)
  );
  pong_btn_edge #(.SYNC(1'b0)) u_miss2_edge (
    .clk(clk), .rst_n(rst_n), .din(miss2), .pulse(miss2_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      win_q   <= WIN_NONE;
      dir_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      br_q    <= br_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    dir_d   = dir_q;
    br_d    = 1'b0;
    case (state_q)
      IDLE: begin
        s1_d  = '0;
        s2_d  = '0;
        win_d = WIN_NONE;
        if (start_p) begin
          state_d = SERVE;
          br_d    = 1'b1;
        end
      end
      SERVE: if (start_p) state_d = PLAY;
      PLAY: begin
        // Scores update first so a coincident time_up judges the new totals.
        if (miss1_p && miss2_p) begin
          dir_d = ~dir_q;
        end else if (miss1_p) begin
          s2_d  = s2_q + 1'b1;
          dir_d = 1'b0;
        end else if (miss2_p) begin
          s1_d  = s1_q + 1'b1;
          dir_d = 1'b1;
        end
        if (s1_d == WIN || s2_d == WIN || time_up) begin
          state_d = OVER;
          win_d   = winner_of(s1_d, s2_d);
          cnt_d   = '0;
        end else if (miss1_p || miss2_p) begin
          state_d = POINT;
          cnt_d   = '0;
        end
`ifdef PONG_PAUSE_EN
        else if (start_p) begin
          state_d = PAUSED;
        end
`endif
      end
      POINT: begin
        if (tick) begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = SERVE;
            br_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OVER: begin
        if (tick && cnt_q != OVER_MAX) cnt_d = cnt_q + 1'b1;
        if (start_p && cnt_q == OVER_MAX) begin
          state_d = IDLE;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = WIN_NONE;
          cnt_d   = '0;
        end
      end
`ifdef PONG_PAUSE_EN
      PAUSED: if (start_p) state_d = PLAY;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign stop       = (state_q != PLAY);
  assign ball_reset = br_q;
  assign serve_dir  = dir_q;
  assign score1     = s1_q;
  assign score2     = s2_q;
  assign winner     = win_q;
  assign state      = state_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (WIN_SCORE >= 1 && WIN_SCORE <= 7)
      else $error("pong_match_sequencer: WIN_SCORE=%0d outside 1..7", WIN_SCORE);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pong_match_sequencer.sv
// Self-checking bench for pong_match_sequencer: randomized rallies and tick
// streams compared against a score/serve model derived from the match rules.
`default_nettype none

module tb_pong_match_sequencer;

  localparam int WIN   = 7;
  localparam int PAUSE = 200;
  localparam int OVERT = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, miss1 = 1'b0, miss2 = 1'b0, time_up = 1'b0;
  logic       stop, ball_reset, serve_dir;
  logic [2:0] score1, score2, state;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;

  int m_s1 = 0, m_s2 = 0, m_win = 0;
  bit m_dir = 1'b0, m_over = 1'b0;

  pong_match_sequencer #(
    .WIN_SCORE(WIN), .PAUSE_TICKS(PAUSE), .OVER_TICKS(OVERT), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .miss1(miss1),
    .miss2(miss2), .time_up(time_up), .stop(stop), .ball_reset(ball_reset),
    .serve_dir(serve_dir), .score1(score1), .score2(score2), .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int exp_winner(input int a, input int b);
    return (a > b) ? 1 : ((b > a) ? 2 : 3);
  endfunction

  task automatic press_start();
    start = 1'b1;
    clk_n(4);
    start = 1'b0;
    clk_n(3);
  endtask

  task automatic check_all(input string tag, input int st);
    chk({tag, "_state"}, state, st);
    chk({tag, "_stop"}, stop, (st == 2) ? 1 : 0 ^ 1);
    chk({tag, "_s1"}, score1, m_s1);
    chk({tag, "_s2"}, score2, m_s2);
    chk({tag, "_win"}, winner, m_win);
  endtask

  // Random tick stream with random start presses; must leave POINT after exactly PAUSE ticks.
  task automatic wait_point_to_serve();
    int ticks = 0;
    int cyc = 0;
    bit early = 1'b0;
    while (ticks < PAUSE && cyc < 3000) begin
      tick  = 1'($urandom_range(0, 1));
      start = (ticks < PAUSE - 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
      if (tick) ticks++;
      if (ticks < PAUSE && (state !== 3'd3 || ball_reset !== 1'b0)) early = 1'b1;
    end
    tick  = 1'b0;
    start = 1'b0;
    chk("point_hold", early, 0);
    chk("point_ticks", ticks, PAUSE);
    chk("serve_br", ball_reset, 1);
    chk("serve_state", state, 1);
    @(negedge clk);
    chk("br_single", ball_reset, 0);
  endtask

  // who: bit0 = miss1, bit1 = miss2; tu = time_up in the same clk.
  task automatic play_point(input int who, input bit tu);
    if (who == 1) begin m_s2++; m_dir = 1'b0; end
    else if (who == 2) begin m_s1++; m_dir = 1'b1; end
    else if (who == 3) m_dir = ~m_dir;
    m_over = (m_s1 == WIN) || (m_s2 == WIN) || tu;
    m_win  = m_over ? exp_winner(m_s1, m_s2) : 0;
    miss1   = 1'(who & 1);
    miss2   = 1'((who >> 1) & 1);
    time_up = tu;
    @(negedge clk);
    miss1 = 1'b0; miss2 = 1'b0; time_up = 1'b0;
    check_all("point", m_over ? 4 : 3);
    chk("point_dir", serve_dir, m_dir);
    if (!m_over) begin
      wait_point_to_serve();
      press_start();
      chk("replay_state", state, 2);
    end
  endtask

  task automatic leave_over();
    tick = 1'b1;
    clk_n(100);
    tick = 1'b0;
    press_start();
    check_all("over_early", 4);
    tick = 1'b1;
    clk_n(OVERT + 5);
    tick = 1'b0;
    press_start();
    m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 1'b0;
    check_all("over_exit", 0);
  endtask

  task automatic new_match();
    press_start();
    chk("nm_serve", state, 1);
    press_start();
    chk("nm_play", state, 2);
    chk("nm_stop", stop, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int brs;
    int br_at;
    clk_n(3);
    check_all("reset", 0);
    chk("reset_br", ball_reset, 0);
    chk("reset_dir", serve_dir, 0);
    rst_n = 1'b1;
    clk_n(2);

    // Held button: one ball_reset pulse, 3 clk after the raw edge.
    brs = 0; br_at = 0;
    start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ball_reset) begin brs++; br_at = i; end
    end
    start = 1'b0;
    clk_n(3);
    chk("hold_pulses", brs, 1);
    chk("hold_latency", br_at, 3);
    chk("hold_state", state, 1);
    press_start();
    chk("play_state", state, 2);
    chk("play_stop", stop, 0);

    // Match A: simultaneous miss first, then random misses to completion.
    play_point(3, 1'b0);
    for (int n = 0; n < 20 && !m_over; n++) play_point(int'($urandom_range(1, 2)), 1'b0);
    chk("matchA_over", m_over, 1);
    leave_over();

    // Match B: 2:2 then time_up alone -> draw.
    new_match();
    play_point(2, 1'b0); play_point(1, 1'b0); play_point(2, 1'b0); play_point(1, 1'b0);
    play_point(0, 1'b1);
    chk("draw_code", winner, 3);
    leave_over();

    // Match C: 2:2 then miss2 with time_up -> 3:2, player 1 wins.
    new_match();
    play_point(1, 1'b0); play_point(2, 1'b0); play_point(1, 1'b0); play_point(2, 1'b0);
    play_point(2, 1'b1);
    chk("tu_s1", score1, 3);
    chk("tu_win", winner, 1);
    leave_over();

    // Asynchronous reset mid-POINT.
    new_match();
    miss1 = 1'b1;
    @(negedge clk);
    miss1 = 1'b0;
    chk("pre_rst_point", state, 3);
    tick = 1'b1;
    clk_n(150);
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 1'b0;
    check_all("async_rst", 0);
    chk("async_rst_br", ball_reset, 0);
    chk("async_rst_dir", serve_dir, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clk_n(2);

    new_match();
`ifdef PONG_PAUSE_EN
    press_start();
    chk("pause_state", state, 5);
    chk("pause_stop", stop, 1);
    press_start();
    chk("resume_state", state, 2);
    chk("resume_stop", stop, 0);
`else
    press_start();
    chk("nopause_state", state, 2);
    chk("nopause_stop", stop, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
